// File: rtl/pong_pkg.sv
`default_nettype none
//============================================================================
// Module      : pong_pkg
// Description : Shared 3D Pong types and constants: rally referee states,
//               score ceiling, default serve/grace timing, score helper.
// Revision    : 1.0 - initial release
//============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    RALLY  = 3'd2,
    CHECK  = 3'd3,
    RETURN = 3'd4,
    MISSED = 3'd5
  } rally_state_t;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  localparam int SERVE_FRAMES_DEF = 30;
  localparam int GRACE_FRAMES_DEF = 2;

  // Saturating score increment: the score sticks at SCORE_MAX.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == SCORE_MAX) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rally_scorer_if.sv
`default_nettype none
//============================================================================
// Module      : rally_scorer_if
// Description : Level-controller / collision-logic side of the rally
//               referee: level control, ball events in, score/pulses out.
// Revision    : 1.0 - initial release
//============================================================================
interface rally_scorer_if;

  logic       level_rst;
  logic       pause;
  logic       paddle_hit;
  logic       ball_at_near;
  logic       ball_at_far;
  logic [7:0] score;
  logic       miss;
  logic       launch;
  logic       rally_active;

  // Environment side: drives control and ball events, observes the referee.
  modport master (
    output level_rst, pause, paddle_hit, ball_at_near, ball_at_far,
    input  score, miss, launch, rally_active
  );

  // Referee side.
  modport slave (
    input  level_rst, pause, paddle_hit, ball_at_near, ball_at_far,
    output score, miss, launch, rally_active
  );

endinterface
`default_nettype wire

// File: rtl/event_edge.sv
`default_nettype none
//============================================================================
// Module      : event_edge
// Description : One-bit registered rise detector. The history register
//               follows the input every frame, so the rise output is
//               x & ~x_q.
// Revision    : 1.0 - initial release
//============================================================================
module event_edge (
  input  logic frame_clk,
  input  logic game_rst_n,
  input  logic x,
  output logic rise
);

  logic r_x_q;

  // Previous-frame copy of the level input; updates unconditionally.
  always_ff @(posedge frame_clk or negedge game_rst_n) begin
    if (!game_rst_n) begin
      r_x_q <= 1'b0;
    end else begin
      r_x_q <= x;
    end
  end

  assign rise = x & ~r_x_q;

endmodule
`default_nettype wire

// File: rtl/rally_scorer.sv
`default_nettype none
//============================================================================
// Module      : rally_scorer
// Description : Per-level rally referee. Runs the serve delay, scores paddle
//               returns (saturating at 255), grants a short grace window after
//               a near-plane arrival and raises one-cycle launch/miss pulses.
// Revision    : 1.0 - initial release
//============================================================================
module rally_scorer
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEF
) (
  input  logic          frame_clk,
  input  logic          game_rst_n,
  rally_scorer_if.slave bus
);

  localparam logic [7:0] c_serve_last = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] c_grace_last = 4'(GRACE_FRAMES - 1);

  // Event bit positions inside the edge-detector vectors.
  localparam int c_evt_hit  = 0;
  localparam int c_evt_near = 1;
  localparam int c_evt_far  = 2;

  logic [2:0]   w_evt_lvl;
  logic [2:0]   w_evt_rise;
  logic         w_hit_rise;
  logic         w_near_rise;
  logic         w_far_rise;

  rally_state_t r_state;
  rally_state_t w_state_nxt;
  logic [7:0]   r_serve_cnt;
  logic [7:0]   w_serve_cnt_nxt;
  logic [3:0]   r_grace_cnt;
  logic [3:0]   w_grace_cnt_nxt;
  logic [7:0]   r_score;
  logic [7:0]   w_score_nxt;
  logic         r_miss;
  logic         w_miss_nxt;
  logic         r_launch;
  logic         w_launch_nxt;

  assign w_evt_lvl = {bus.ball_at_far, bus.ball_at_near, bus.paddle_hit};

  for (genvar g = 0; g < 3; g++) begin : g_evt_edge
    event_edge u_edge (
      .frame_clk  (frame_clk),
      .game_rst_n (game_rst_n),
      .x          (w_evt_lvl[g]),
      .rise       (w_evt_rise[g])
    );
  end

  assign w_hit_rise  = w_evt_rise[c_evt_hit];
  assign w_near_rise = w_evt_rise[c_evt_near];
  assign w_far_rise  = w_evt_rise[c_evt_far];

  // State, counters, score and output pulses advance on each frame.
  always_ff @(posedge frame_clk or negedge game_rst_n) begin
    if (!game_rst_n) begin
      r_state     <= IDLE;
      r_serve_cnt <= 8'd0;
      r_grace_cnt <= 4'd0;
      r_score     <= 8'd0;
      r_miss      <= 1'b0;
      r_launch    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_serve_cnt <= w_serve_cnt_nxt;
      r_grace_cnt <= w_grace_cnt_nxt;
      r_score     <= w_score_nxt;
      r_miss      <= w_miss_nxt;
      r_launch    <= w_launch_nxt;
    end
  end

  // Next-state logic: level restart beats pause, pause freezes everything
  // but still kills the pulses, otherwise the rally rules apply.
  always_comb begin
    w_state_nxt     = r_state;
    w_serve_cnt_nxt = r_serve_cnt;
    w_grace_cnt_nxt = r_grace_cnt;
    w_score_nxt     = r_score;
    w_miss_nxt      = 1'b0;
    w_launch_nxt    = 1'b0;

    if (bus.level_rst) begin
      w_state_nxt     = SERVE;
      w_serve_cnt_nxt = 8'd0;
      w_grace_cnt_nxt = 4'd0;
      w_score_nxt     = 8'd0;
    end else if (!bus.pause) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        SERVE: begin
          if (r_serve_cnt == c_serve_last) begin
            w_launch_nxt    = 1'b1;
            w_serve_cnt_nxt = 8'd0;
            w_state_nxt     = RALLY;
          end else begin
            w_serve_cnt_nxt = r_serve_cnt + 8'd1;
          end
        end
        RALLY: begin
          // A hit arriving together with the near edge counts as a return.
          if (w_hit_rise) begin
            w_score_nxt = sat_inc(r_score);
            w_state_nxt = RETURN;
          end else if (w_near_rise) begin
            w_grace_cnt_nxt = 4'd0;
            w_state_nxt     = CHECK;
          end
        end
        CHECK: begin
          if (w_hit_rise) begin
            w_score_nxt = sat_inc(r_score);
            w_state_nxt = RETURN;
          end else if (r_grace_cnt == c_grace_last) begin
            w_miss_nxt  = 1'b1;
            w_state_nxt = MISSED;
          end else begin
            w_grace_cnt_nxt = r_grace_cnt + 4'd1;
          end
        end
        RETURN: begin
          // Ball is travelling away; paddle and near events are ignored
          // until it reaches the far wall.
          if (w_far_rise) begin
            w_state_nxt = RALLY;
          end
        end
        MISSED: begin
          w_state_nxt = MISSED;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.score        = r_score;
  assign bus.miss         = r_miss;
  assign bus.launch       = r_launch;
  assign bus.rally_active = (r_state == RALLY) || (r_state == CHECK) ||
                            (r_state == RETURN);

endmodule
`default_nettype wire

// File: doc/rally_scorer.md
# rally_scorer

Per-level rally referee for 3D Pong and the producing end of the level controller's `score`/`miss` interface. It sits between the ball/paddle collision logic and the level controller. It consumes `level_rst`, `pause` and the ball events, and returns `score` (successful paddle returns this level), a one-cycle `miss` pulse and a serve `launch` pulse for the ball engine.

## Interface
- `SERVE_FRAMES`, default 30: unpaused frames between level start and ball launch; legal range 1..255.
- `GRACE_FRAMES`, default 2: frames a near-plane arrival waits for a paddle contact before declaring a miss; legal range 1..15.
- `frame_clk` in 1: frame clock; all logic is on its rising edge.
- `game_rst_n` in 1: asynchronous, active-low reset.
- `level_rst` in 1: synchronous level restart from the level controller; highest priority after reset.
- `pause` in 1: freezes the FSM, counters and score.
- `paddle_hit` in 1: level signal; ball overlaps the paddle at the near plane.
- `ball_at_near` in 1: level signal; ball z has reached the near plane.
- `ball_at_far` in 1: level signal; ball z has reached the far wall.
- `score` out 8: paddle returns this level; saturates at 255.
- `miss` out 1: one-cycle registered pulse when a near-plane arrival goes unreturned.
- `launch` out 1: one-cycle registered pulse when the serve delay expires.
- `rally_active` out 1: high in RALLY, CHECK and RETURN.

## Operation
- Event inputs use rise detection: the event is `x & ~x_q`, where `x_q` is the registered previous value. `x_q` updates every cycle, including while paused, so an edge that occurs during pause is lost.
- States:
  - IDLE (reset state): exits only on `level_rst`.
  - SERVE: counts unpaused frames. When the count reaches SERVE_FRAMES-1, pulse `launch` and go to RALLY.
  - RALLY:
    - hit edge → score+1, go to RETURN.
    - near edge without a hit edge → go to CHECK and clear the grace counter.
    - simultaneous hit and near edges count as a hit.
  - CHECK:
    - hit edge → score+1, go to RETURN.
    - else, if grace count = GRACE_FRAMES-1 → pulse `miss`, go to MISSED.
    - else, increment the grace count.
  - RETURN:
    - far edge → RALLY.
    - hit and near edges are ignored (double-hit protection).
  - MISSED: holds until `level_rst`. It exits only on `level_rst`.
- `level_rst`:
  - Next state SERVE, all counters 0, `score` 0, `miss` and `launch` 0, regardless of state or `pause`.
  - While `level_rst` is held, the block stays in SERVE with the count at 0.
- `pause`:
  - All state, counters and `score` hold.
  - `miss` and `launch` are forced 0.
  - Takes effect the same edge it is sampled.
- Score arithmetic: 8-bit unsigned; at 255 a further hit leaves 255 and the FSM still goes to RETURN.
- Hit and far edges outside their listed states are ignored.

## Timing
- Reset values: state IDLE, `score` 0, `miss` 0, `launch` 0, `rally_active` 0, edge registers 0, counters 0.
- Event edge sampled at clock edge k:
  - `score` increments and the state changes at edge k, visible in the following cycle.
  - `miss` and `launch` are high exactly during cycle k..k+1.
- CHECK entered at edge k with no hit and no pause: `miss` is asserted after edge k+GRACE_FRAMES. A hit edge at any edge k+1..k+GRACE_FRAMES prevents the miss.
- SERVE: `launch` follows the SERVE_FRAMES-th unpaused edge after the last edge at which `level_rst` was high.
- Reset asserted mid-rally: outputs clear immediately and asynchronously. Recovery requires a `level_rst`.

## Structure
- Shared package `pong_pkg`:
  - `rally_state_t` enum {IDLE, SERVE, RALLY, CHECK, RETURN, MISSED}.
  - `SCORE_MAX` = 8'd255.
  - Default constants for SERVE_FRAMES and GRACE_FRAMES.
- Sub-module `event_edge`: one-bit registered rise detector with async active-low reset, instantiated three times.
- Counter widths: serve counter 8 bits, grace counter 4 bits.

## Test plan
- Reset, `level_rst` for 1 cycle, `pause`=0 with SERVE_FRAMES=30 → `launch` high exactly 30 cycles later for 1 cycle; `rally_active` rises the same cycle.
- Three hit→far cycles → `score` = 3, `miss` never asserted.
- Near edge alone with GRACE_FRAMES=2 → `miss` high on the second cycle after the near edge, for 1 cycle; state MISSED; further hits leave `score` unchanged.
- Near edge, then a hit edge one cycle later → `score`+1, no `miss`; `paddle_hit` held high for 5 cycles gives only +1.
- `pause` asserted during SERVE for 10 cycles → `launch` delayed by exactly 10 cycles; a hit edge during pause is not scored after unpause.
- Preload 255 hits → `score` stays 255; `game_rst_n` low mid-RALLY → all outputs 0 asynchronously; `level_rst` restarts SERVE.
